// File: rtl/lpc_synth_10_if.sv
// lpc_synth_10_if: residual-in / sample-out handshake, coefficient load port and status for lpc_synth_10.
interface lpc_synth_10_if #(
    parameter int DW = 16,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_residual;
    logic          coef_we;
    logic [3:0]    coef_addr;
    logic [CW-1:0] coef_data;
    logic          clear_hist;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sample;
    logic          busy;

    modport master (
        output in_valid, in_residual, coef_we, coef_addr, coef_data, clear_hist, out_ready,
        input  in_ready, out_valid, out_sample, busy
    );

    modport slave (
        input  in_valid, in_residual, coef_we, coef_addr, coef_data, clear_hist, out_ready,
        output in_ready, out_valid, out_sample, busy
    );
endinterface

// File: rtl/lpc_synth_10.sv
// lpc_synth_10: 10th-order all-pole LPC synthesis filter, one shared MAC over 10 cycles per sample.
// Define LPC_SYNTH_SAT_EN to saturate the output/history instead of two's-complement wrap.
module lpc_synth_10 #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int CFRAC = 12,
    parameter int AW    = 40
) (
    input  logic         clk,
    input  logic         rst,
    lpc_synth_10_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic signed [AW-1:0] HALF = AW'(1) << (CFRAC - 1);

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [3:0]             k_q, k_d;
    logic [DW-1:0]          out_q, out_d;
    logic signed [DW-1:0]   hist_q [10];
    logic signed [DW-1:0]   hist_d [10];
    logic signed [CW-1:0]   coef_q [10];
    logic signed [CW-1:0]   coef_d [10];
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]   acc_sum;
    logic signed [AW-1:0]   rnd_sum;
    logic signed [AW-1:0]   shifted;
    logic [DW-1:0]          fmt_v;

    // Datapath: one tap per cycle, and the rounded/reduced value of the final sum.
    always_comb begin
        prod    = coef_q[k_q] * hist_q[k_q];
        acc_sum = acc_q + {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
        rnd_sum = acc_sum + HALF;
        shifted = rnd_sum >>> CFRAC;
    end

`ifdef LPC_SYNTH_SAT_EN
    localparam logic signed [AW-1:0] SMAX = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = -SMAX - 1;

    always_comb begin
        fmt_v = shifted > SMAX ? SMAX[DW-1:0] : shifted < SMIN ? SMIN[DW-1:0] : shifted[DW-1:0];
    end
`else
    logic unused_hi;

    always_comb begin
        fmt_v     = shifted[DW-1:0];
        unused_hi = ^shifted[AW-1:DW];
    end
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        k_d     = k_q;
        out_d   = out_q;
        for (int i = 0; i < 10; i++) begin
            hist_d[i] = hist_q[i];
            coef_d[i] = (state_q == IDLE && bus.coef_we && bus.coef_addr == 4'(i)) ? bus.coef_data : coef_q[i];
        end
        case (state_q)
            IDLE: begin
                if (bus.clear_hist)
                    for (int i = 0; i < 10; i++) hist_d[i] = '0;
                if (bus.in_valid) begin
                    state_d = MAC;
                    acc_d   = {{(AW-DW){bus.in_residual[DW-1]}}, bus.in_residual} << CFRAC;
                    k_d     = '0;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + 4'd1;
                if (k_q == 4'd9) begin
                    out_d     = fmt_v;
                    hist_d[0] = fmt_v;
                    for (int i = 1; i < 10; i++) hist_d[i] = hist_q[i-1];
                    k_d     = '0;
                    state_d = OUT;
                end
            end
            OUT: state_d = bus.out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            out_q   <= '0;
            for (int i = 0; i < 10; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            out_q   <= out_d;
            for (int i = 0; i < 10; i++) begin
                hist_q[i] <= hist_d[i];
                coef_q[i] <= coef_d[i];
            end
        end
    end

    assign bus.in_ready   = state_q == IDLE;
    assign bus.out_valid  = state_q == OUT;
    assign bus.busy       = state_q != IDLE;
    assign bus.out_sample = out_q;
endmodule

// File: tb/tb_lpc_synth_10.sv
// tb_lpc_synth_10: directed plus randomized bench for lpc_synth_10 against a sample-level reference model.
module tb_lpc_synth_10;
    logic clk = 1'b0;
    logic rst = 1'b1;

    lpc_synth_10_if #(.DW(16), .CW(16)) bus ();

    lpc_synth_10 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: a sample takes 10 cycles after acceptance, then waits in an output phase.
    int          coef_m [10];
    int          hist_m [10];
    int          phase;
    int          e_m;
    logic [15:0] out_m;

    function automatic logic [15:0] predict(int e, int h[10], int c[10]);
        longint acc;
        longint r;
        acc = longint'(e) * 4096;
        for (int k = 0; k < 10; k++) acc += longint'(c[k]) * longint'(h[k]);
        r = (acc + 2048) >>> 12;
`ifdef LPC_SYNTH_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 0;
            e_m   <= 0;
            out_m <= '0;
            for (int i = 0; i < 10; i++) begin
                coef_m[i] <= 0;
                hist_m[i] <= 0;
            end
        end else if (phase == 0) begin
            if (bus.coef_we && bus.coef_addr < 10) coef_m[bus.coef_addr] <= $signed(bus.coef_data);
            if (bus.clear_hist)
                for (int i = 0; i < 10; i++) hist_m[i] <= 0;
            if (bus.in_valid) begin
                phase <= 1;
                e_m   <= $signed(bus.in_residual);
            end
        end else if (phase < 10) begin
            phase <= phase + 1;
        end else if (phase == 10) begin
            out_m     <= predict(e_m, hist_m, coef_m);
            hist_m[0] <= $signed(predict(e_m, hist_m, coef_m));
            for (int i = 1; i < 10; i++) hist_m[i] <= hist_m[i-1];
            phase <= 11;
        end else if (bus.out_ready) begin
            phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", bus.in_ready, phase == 0);
            chk("out_valid", bus.out_valid, phase == 11);
            chk("busy", bus.busy, phase != 0);
            chk("out_sample", bus.out_sample, out_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait();
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", bus.in_ready, 1);
    endtask

    task automatic wcoef(int a, int d);
        idle_wait();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'(a);
        bus.coef_data = 16'(d);
        tick();
        bus.coef_we = 1'b0;
    endtask

    task automatic send(int e, bit clr);
        idle_wait();
        bus.in_valid    = 1'b1;
        bus.in_residual = 16'(e);
        bus.clear_hist  = clr;
        tick();
        bus.in_valid   = 1'b0;
        bus.clear_hist = 1'b0;
    endtask

    task automatic get(output logic [15:0] v);
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("out_timeout", bus.out_valid, 1);
        v = bus.out_sample;
        tick();
    endtask

    task automatic xfer(string name, int e, bit clr, int exp);
        logic [15:0] v;
        send(e, clr);
        get(v);
        chk(name, v, exp);
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] v0;
        int n;
        bus.in_valid    = 1'b0;
        bus.in_residual = '0;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_data   = '0;
        bus.clear_hist  = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_out_sample", bus.out_sample, 0);

        send('h0123, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            chk("bypass_in_ready_low", bus.in_ready, 0);
            tick();
            n++;
        end
        chk("bypass_latency", n, 10);
        chk("bypass_sample", bus.out_sample, 'h0123);
        tick();

        wcoef(0, 'h0800);
        xfer("decay0", 100, 1'b1, 100);
        xfer("decay1", 0, 1'b0, 50);
        xfer("decay2", 0, 1'b0, 25);
        xfer("decay3", 0, 1'b0, 13);
        xfer("decay4", 0, 1'b0, 7);

        wcoef(0, 'h1000);
        xfer("ovf0", 'h7000, 1'b1, 'h7000);
`ifdef LPC_SYNTH_SAT_EN
        xfer("ovf1", 'h7000, 1'b0, 'h7FFF);
`else
        xfer("ovf1", 'h7000, 1'b0, 'hE000);
`endif

        bus.out_ready = 1'b0;
        send(42, 1'b1);
        bus.in_valid    = 1'b1;
        bus.in_residual = 16'd55;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        v0 = bus.out_sample;
        chk("bp_first", v0, 42);
        repeat (5) begin
            tick();
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_hold", bus.out_sample, v0);
        end
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while ((bus.in_ready || bus.out_valid) && n < 10);
        bus.in_valid = 1'b0;
        chk("bp_accept_delay", n, 2);
        get(v);
        chk("bp_second", v, 97);

        xfer("prime500", 500, 1'b1, 500);
        send(123, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("midmac_out_valid", bus.out_valid, 0);
        chk("midmac_in_ready", bus.in_ready, 1);
        chk("midmac_busy", bus.busy, 0);
        chk("midmac_out_sample", bus.out_sample, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wcoef(0, 'h1000);
        xfer("after_reset", 10, 1'b0, 10);

        wcoef(0, 0);
        send(77, 1'b0);
        tick();
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 16'h1000;
        tick();
        bus.coef_we = 1'b0;
        get(v);
        chk("mac_write_out", v, 77);
        xfer("mac_write_ignored", 5, 1'b0, 5);
        for (int i = 0; i < 10; i++) xfer("fill", i + 1, 1'b0, i + 1);
        wcoef(12, 'h1000);
        wcoef(15, 'h1000);
        xfer("bad_addr_ignored", 9, 1'b0, 9);

        wcoef(0, 'h1000);
        xfer("prime300", 300, 1'b1, 300);
        xfer("clear_with_valid", 7, 1'b1, 7);

        for (int c = 0; c < 4000; c++) begin
            bus.in_valid    = $urandom_range(0, 1) == 1;
            bus.in_residual = 16'($urandom);
            bus.coef_we     = $urandom_range(0, 9) == 0;
            bus.coef_addr   = 4'($urandom_range(0, 15));
            bus.coef_data   = 16'(int'($urandom_range(0, 'h1000)) - 'h800);
            bus.clear_hist  = $urandom_range(0, 19) == 0;
            bus.out_ready   = $urandom_range(0, 9) < 7;
            tick();
        end
        bus.in_valid   = 1'b0;
        bus.coef_we    = 1'b0;
        bus.clear_hist = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
